// File: rtl/alp_issuer_pkg.sv
// alp_issuer_pkg: shared types and constants for the ALP command issuer.
//   state_t - sequencing states of the issuer FSM
//   CNT_W   - width of the shared phase down-counter
//   OP_W    - ALP opcode width
//   DATA_W  - ALP data / register width
package alp_issuer_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        GAP_C,
        LOAD_A,
        GAP_A,
        LOAD_B,
        GAP_B,
        COMP,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/alp_cmd_issuer_if.sv
// alp_cmd_issuer_if: command/response channel between a host and the issuer.
// Signal names are issuer-relative (i_ = into the issuer, o_ = out of it).
//   i_cmd_valid/o_cmd_ready         - command handshake
//   i_cmd_clr/i_cmd_op/i_cmd_a/i_cmd_b - command fields
//   o_rsp_valid/i_rsp_ready         - response handshake
//   o_rsp_r0/o_rsp_r1/o_rsp_err     - captured ALP results
// Modports: master = host side, slave = issuer side.
interface alp_cmd_issuer_if;
    import alp_issuer_pkg::*;

    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_clr;
    logic [OP_W-1:0]   i_cmd_op;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_r0;
    logic [DATA_W-1:0] o_rsp_r1;
    logic              o_rsp_err;

    modport master (
        output i_cmd_valid, i_cmd_clr, i_cmd_op, i_cmd_a, i_cmd_b, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_r0, o_rsp_r1, o_rsp_err
    );

    modport slave (
        input  i_cmd_valid, i_cmd_clr, i_cmd_op, i_cmd_a, i_cmd_b, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_r0, o_rsp_r1, o_rsp_err
    );

endinterface

// File: rtl/alp_issuer_timer.sv
// alp_issuer_timer: loadable down-counter timing each issuer phase.
//   clk        - system clock
//   i_rst_n    - synchronous active-low reset
//   i_load     - load i_load_val (takes priority over counting)
//   i_load_val - phase length in cycles
//   o_done     - current cycle is the last one of the phase (count == 1)
module alp_issuer_timer
    import alp_issuer_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/alp_cmd_issuer.sv
// alp_cmd_issuer: front-panel driver for the ALP. Accepts one command, pulses
// the ALP LOAD/COMP/CLR inputs, waits COMP_WAIT cycles and returns R0/R1/ERR.
//   clk, i_rst_n  - clock, synchronous active-low reset
//   host          - command/response channel (alp_cmd_issuer_if.slave)
//   o_OP, o_DATA_IN, o_LOAD, o_COMP, o_CLR - drive the ALP inputs
//   i_R0, i_R1, i_ERR                      - ALP results
//   o_busy        - high whenever the FSM is not in IDLE
// Optional: define ALP_ISSUER_STATS_EN to add o_cmd_cnt / o_err_cnt
// (saturating counts of accepted commands and consumed error responses).
module alp_cmd_issuer
    import alp_issuer_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 1,
    parameter int unsigned COMP_WAIT = 8
) (
    input  logic              clk,
    input  logic              i_rst_n,
    alp_cmd_issuer_if.slave   host,
    output logic [OP_W-1:0]   o_OP,
    output logic [DATA_W-1:0] o_DATA_IN,
    output logic              o_LOAD,
    output logic              o_COMP,
    output logic              o_CLR,
    input  logic [DATA_W-1:0] i_R0,
    input  logic [DATA_W-1:0] i_R1,
    input  logic              i_ERR,
    output logic              o_busy
`ifdef ALP_ISSUER_STATS_EN
    ,
    output logic [15:0]       o_cmd_cnt,
    output logic [15:0]       o_err_cnt
`endif
);

    state_t            r_state;
    state_t            w_next;

    logic              r_clr;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_r0;
    logic [DATA_W-1:0] r_rsp_r1;
    logic              r_rsp_err;
    logic [OP_W-1:0]   r_OP;
    logic [DATA_W-1:0] r_DATA_IN;
    logic              r_LOAD;
    logic              r_COMP;
    logic              r_CLR;

    logic              w_accept;
    logic              w_consume;
    logic              w_done;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;

    assign w_accept  = host.i_cmd_valid && r_cmd_ready;
    assign w_consume = r_rsp_valid && host.i_rsp_ready;

    alp_issuer_timer u_timer (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus timer reload: the counter is reloaded with the length
    // of the phase being entered on every state change.
    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = host.i_cmd_clr ? CLR : LOAD_A;
            CLR:     if (w_done) w_next = GAP_C;
            GAP_C:   if (w_done) w_next = WAIT;
            LOAD_A:  if (w_done) w_next = GAP_A;
            GAP_A:   if (w_done) w_next = LOAD_B;
            LOAD_B:  if (w_done) w_next = GAP_B;
            GAP_B:   if (w_done) w_next = COMP;
            COMP:    if (w_done) w_next = WAIT;
            WAIT:    if (w_done) w_next = RESP;
            RESP:    if (w_consume) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_tmr_load = (w_next != r_state);
        unique case (w_next)
            CLR, LOAD_A, LOAD_B, COMP: w_tmr_val = CNT_W'(PULSE_CYC);
            GAP_C, GAP_A, GAP_B:       w_tmr_val = CNT_W'(GAP_CYC);
            WAIT:                      w_tmr_val = CNT_W'(COMP_WAIT);
            default:                   w_tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_clr <= 1'b0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_clr <= host.i_cmd_clr;
            r_op  <= host.i_cmd_op;
            r_a   <= host.i_cmd_a;
            r_b   <= host.i_cmd_b;
        end
    end

    // Output stage. ALP drives and the response are registered from the
    // current state, so they trail the state by one cycle; this extra cycle
    // is what makes the accept-to-valid latency PULSE/GAP/WAIT sum + 1.
    // The response is captured on the cycle valid rises, i.e. COMP_WAIT
    // full cycles after o_COMP (or o_CLR) has fallen at the ALP.
    // Ready/busy are registered from the next state so a command can be
    // accepted the cycle right after a consume.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_r0    <= '0;
            r_rsp_r1    <= '0;
            r_rsp_err   <= 1'b0;
            r_OP        <= '0;
            r_DATA_IN   <= '0;
            r_LOAD      <= 1'b0;
            r_COMP      <= 1'b0;
            r_CLR       <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
            r_CLR       <= (r_state == CLR);
            r_LOAD      <= (r_state == LOAD_A) || (r_state == LOAD_B);
            r_COMP      <= (r_state == COMP);
            r_OP        <= ((r_state == IDLE) || r_clr) ? '0 : r_op;
            unique case (r_state)
                LOAD_A, GAP_A:   r_DATA_IN <= r_a;
                LOAD_B, GAP_B:   r_DATA_IN <= r_b;
                IDLE, CLR, GAP_C: r_DATA_IN <= '0;
                default:         r_DATA_IN <= r_DATA_IN;
            endcase
            if ((r_state == RESP) && !r_rsp_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_r0    <= i_R0;
                r_rsp_r1    <= i_R1;
                r_rsp_err   <= i_ERR;
            end else if (w_consume) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign host.o_cmd_ready = r_cmd_ready;
    assign host.o_rsp_valid = r_rsp_valid;
    assign host.o_rsp_r0    = r_rsp_r0;
    assign host.o_rsp_r1    = r_rsp_r1;
    assign host.o_rsp_err   = r_rsp_err;
    assign o_OP             = r_OP;
    assign o_DATA_IN        = r_DATA_IN;
    assign o_LOAD           = r_LOAD;
    assign o_COMP           = r_COMP;
    assign o_CLR            = r_CLR;
    assign o_busy           = r_busy;

`ifdef ALP_ISSUER_STATS_EN
    logic [15:0] r_cmd_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cmd_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept && (r_cmd_cnt != '1)) begin
                r_cmd_cnt <= r_cmd_cnt + 16'd1;
            end
            if (w_consume && r_rsp_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_cmd_cnt = r_cmd_cnt;
    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_alp_cmd_issuer.sv
// tb_alp_cmd_issuer: directed bench for alp_cmd_issuer with a small ALP model.
// ALP model: each LOAD rising edge shifts R1<=R0, R0<=DATA_IN (so A=R1, B=R0
// after two loads); a COMP rising edge computes op 0 add {R1,R0}={carry,sum},
// op 1 sub R0=A-B with ERR=A<B, op 2 mul {R1,R0}=A*B; CLR zeroes everything.
module tb_alp_cmd_issuer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] op_w;
    logic [3:0] data_w;
    logic       ld_w, cp_w, cl_w, busy_w;
    logic [3:0] m_r0 = '0;
    logic [3:0] m_r1 = '0;
    logic       m_err = 1'b0;
    logic       p_ld = 1'b0, p_cp = 1'b0, p_cl = 1'b0;
    logic [4:0] m_sum, m_dif;
    logic [7:0] m_prod;
`ifdef ALP_ISSUER_STATS_EN
    logic [15:0] cmd_cnt, err_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alp_cmd_issuer_if bus ();

    alp_cmd_issuer #(.PULSE_CYC(2), .GAP_CYC(1), .COMP_WAIT(8)) dut (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .host      (bus),
        .o_OP      (op_w),
        .o_DATA_IN (data_w),
        .o_LOAD    (ld_w),
        .o_COMP    (cp_w),
        .o_CLR     (cl_w),
        .i_R0      (m_r0),
        .i_R1      (m_r1),
        .i_ERR     (m_err),
        .o_busy    (busy_w)
`ifdef ALP_ISSUER_STATS_EN
        ,
        .o_cmd_cnt (cmd_cnt),
        .o_err_cnt (err_cnt)
`endif
    );

    assign m_sum  = {1'b0, m_r1} + {1'b0, m_r0};
    assign m_dif  = {1'b0, m_r1} - {1'b0, m_r0};
    assign m_prod = {4'b0, m_r1} * {4'b0, m_r0};

    always @(posedge clk) begin
        p_ld <= ld_w;
        p_cp <= cp_w;
        p_cl <= cl_w;
        if (cl_w && !p_cl) begin
            m_r0 <= '0; m_r1 <= '0; m_err <= 1'b0;
        end else if (ld_w && !p_ld) begin
            m_r1 <= m_r0; m_r0 <= data_w;
        end else if (cp_w && !p_cp) begin
            case (op_w)
                3'd0:    begin m_r0 <= m_sum[3:0]; m_r1 <= {3'b0, m_sum[4]}; m_err <= 1'b0; end
                3'd1:    begin m_r0 <= m_dif[3:0]; m_r1 <= '0; m_err <= (m_r1 < m_r0); end
                3'd2:    begin m_r0 <= m_prod[3:0]; m_r1 <= m_prod[7:4]; m_err <= 1'b0; end
                default: begin m_r0 <= '0; m_r1 <= '0; m_err <= 1'b0; end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic clr, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_clr   = clr;
        bus.i_cmd_op    = op;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
    endtask

    // Issues one command, records the pulse trace for lat cycles after the
    // accept edge, checks it and the response, optionally consumes it.
    task automatic run_cmd(input string tag, input logic clr, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b, input int lat,
                           input logic [17:0] e_ld, input logic [17:0] e_cp, input logic [17:0] e_cl,
                           input logic [3:0] e_r0, input logic [3:0] e_r1, input logic e_err,
                           input bit consume);
        logic [17:0] v_ld = '0, v_cp = '0, v_cl = '0, v_rv = '0;
        logic [3:0]  d1 = '0, d4 = '0;
        logic [2:0]  o7 = '0;
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.o_cmd_ready), 32'd1);
        drive_cmd(clr, op, a, b);
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy_w), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            v_ld[k] = ld_w;
            v_cp[k] = cp_w;
            v_cl[k] = cl_w;
            v_rv[k] = bus.o_rsp_valid;
            if (k == 1) d1 = data_w;
            if (k == 4) d4 = data_w;
            if (k == 7) o7 = op_w;
        end
        check({tag, "_load"}, 32'(v_ld), 32'(e_ld));
        check({tag, "_comp"}, 32'(v_cp), 32'(e_cp));
        check({tag, "_clr"}, 32'(v_cl), 32'(e_cl));
        check({tag, "_ldcp_overlap"}, 32'(v_ld & v_cp), 32'd0);
        check({tag, "_valid_lat"}, 32'(v_rv), 32'(18'd1 << lat));
        check({tag, "_data_a"}, 32'(d1), clr ? 32'd0 : 32'(a));
        check({tag, "_data_b"}, 32'(d4), clr ? 32'd0 : 32'(b));
        check({tag, "_op"}, 32'(o7), clr ? 32'd0 : 32'(op));
        check({tag, "_r0"}, 32'(bus.o_rsp_r0), 32'(e_r0));
        check({tag, "_r1"}, 32'(bus.o_rsp_r1), 32'(e_r1));
        check({tag, "_err"}, 32'(bus.o_rsp_err), 32'(e_err));
        if (consume) begin
            bus.i_rsp_ready = 1'b1;
            @(negedge clk);
            bus.i_rsp_ready = 1'b0;
            check({tag, "_consumed"}, 32'(bus.o_rsp_valid), 32'd0);
            check({tag, "_ready_after"}, 32'(bus.o_cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int k;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_clr   = 1'b0;
        bus.i_cmd_op    = '0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready", 32'(bus.o_cmd_ready), 32'd1);
        check("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_busy", 32'(busy_w), 32'd0);
        check("rst_pulses", 32'({ld_w, cp_w, cl_w}), 32'd0);
        check("rst_data_op", 32'({data_w, op_w}), 32'd0);
`ifdef ALP_ISSUER_STATS_EN
        check("rst_stats", 32'({cmd_cnt, err_cnt}), 32'd0);
`endif
        rst_n = 1'b1;

        // Add 3+2: LOAD at cycles 1,2 and 4,5, COMP at 7,8, valid at 17
        run_cmd("add", 1'b0, 3'd0, 4'd3, 4'd2, 17, 18'h00036, 18'h00180, 18'h0, 4'd5, 4'd0, 1'b0, 1'b1);
        // Clear: CLR at cycles 1,2, valid at 12, zero response
        run_cmd("clear", 1'b1, 3'd5, 4'd9, 4'd9, 12, 18'h0, 18'h0, 18'h00006, 4'd0, 4'd0, 1'b0, 1'b1);
        // Sub 2-5 borrows: r0=13, ERR=1
        run_cmd("sub", 1'b0, 3'd1, 4'd2, 4'd5, 17, 18'h00036, 18'h00180, 18'h0, 4'd13, 4'd0, 1'b1, 1'b1);
        // Mul 7*6=0x2A, left pending for back-pressure
        run_cmd("mul", 1'b0, 3'd2, 4'd7, 4'd6, 17, 18'h00036, 18'h00180, 18'h0, 4'd10, 4'd2, 1'b0, 1'b0);

        // Back-pressure: response and ready stay put while a clear waits
        drive_cmd(1'b1, 3'd0, 4'd0, 4'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_r0 !== 4'd10 || bus.o_rsp_r1 !== 4'd2 ||
                bus.o_rsp_err !== 1'b0 || bus.o_cmd_ready !== 1'b0 || busy_w !== 1'b1)
                bad++;
        end
        check("bp_stable_cycles_bad", 32'(bad), 32'd0);
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check("bp_consumed", 32'(bus.o_rsp_valid), 32'd0);
        check("bp_not_yet_accepted", 32'(busy_w), 32'd0);
        @(negedge clk);
        check("bp_accepted_busy", 32'(busy_w), 32'd1);
        check("bp_accepted_ready", 32'(bus.o_cmd_ready), 32'd0);
        bus.i_cmd_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("bp_clr_valid_early", 32'(bus.o_rsp_valid), 32'd0);
        @(negedge clk);
        check("bp_clr_valid", 32'(bus.o_rsp_valid), 32'd1);
        check("bp_clr_rsp", 32'({bus.o_rsp_r0, bus.o_rsp_r1, bus.o_rsp_err}), 32'd0);
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;

        // Reset during LOAD_B
        drive_cmd(1'b0, 3'd0, 4'd1, 4'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_load_b", 32'({ld_w, data_w}), 32'h11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_pulses", 32'({ld_w, cp_w, cl_w}), 32'd0);
        check("mid_rst_ready", 32'(bus.o_cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy_w), 32'd0);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.o_rsp_valid !== 1'b0 || busy_w !== 1'b0) bad++;
        end
        check("mid_rst_no_rsp_bad", 32'(bad), 32'd0);

        // Back-to-back with i_rsp_ready tied high
        bus.i_rsp_ready = 1'b1;
        drive_cmd(1'b0, 3'd0, 4'd4, 4'd5);
        @(posedge clk);
        @(negedge clk);
        drive_cmd(1'b0, 3'd1, 4'd3, 4'd9);
        k = 0;
        do begin @(negedge clk); k++; end while (bus.o_rsp_valid !== 1'b1 && k < 40);
        check("b2b1_latency", 32'(k), 32'd17);
        check("b2b1_rsp", 32'({bus.o_rsp_r0, bus.o_rsp_r1, bus.o_rsp_err}), 32'h120);
        @(negedge clk);
        check("b2b1_consumed", 32'({bus.o_rsp_valid, bus.o_cmd_ready}), 32'b01);
        @(negedge clk);
        check("b2b2_accepted", 32'({busy_w, bus.o_cmd_ready}), 32'b10);
        bus.i_cmd_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (bus.o_rsp_valid !== 1'b1 && k < 40);
        check("b2b2_latency", 32'(k), 32'd17);
        check("b2b2_rsp", 32'({bus.o_rsp_r0, bus.o_rsp_r1, bus.o_rsp_err}), 32'h141);
        @(negedge clk);
        check("b2b2_consumed", 32'(bus.o_rsp_valid), 32'd0);
`ifdef ALP_ISSUER_STATS_EN
        check("stats_cmd_cnt", 32'(cmd_cnt), 32'd2);
        check("stats_err_cnt", 32'(err_cnt), 32'd1);
`endif
        bus.i_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
